// File: rtl/cameralink_capture_ctl.sv
// cameralink_capture_ctl: CameraLink frame-grabber sequencer writing RGB pixels into a linear frame buffer
// Ports: CLOCK/RESET link clock and sync active-high reset; start/num_frames/abort run control;
//   VCE/LVV/FVV + red/green/blue receiver stream; cam_enable/cam_request receiver control;
//   wr_en/wr_addr/wr_data frame-buffer write port; busy/frame_done/run_done status;
//   frame_width/frame_height geometry of last frame; err sticky {abort,timeout,width_mismatch,overrun}.
module cameralink_capture_ctl #(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int TIMEOUT    = 100000
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        num_frames,
  input  logic              abort,
  input  logic              VCE,
  input  logic              LVV,
  input  logic              FVV,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              cam_enable,
  output logic              cam_request,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              run_done,
  output logic [15:0]       frame_width,
  output logic [15:0]       frame_height,
  output logic [3:0]        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARM, SYNC, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t state;
  logic [TW-1:0] tmo;
  logic [15:0] x, y;
  logic [ADDR_W-1:0] line_base;
  logic [7:0] frames_left;
  logic lvv_d, fvv_d;
  logic cap, q, fall_f, close, fits, tmo_hit;
  assign cap     = state == CAPTURE;
  assign fall_f  = cap & fvv_d & ~FVV;
  // a line closes on LVV falling, or implicitly when the frame ends with the line still open
  assign close   = cap & ((fvv_d & ~FVV) | (lvv_d & ~LVV)) & (x != 16'd0);
  assign q       = cap & FVV & LVV & VCE;
  assign fits    = (x < 16'(MAX_WIDTH)) && (y < 16'(MAX_HEIGHT));
  assign tmo_hit = tmo == TW'(TIMEOUT - 1);
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= IDLE;
      tmo          <= '0;
      x            <= '0;
      y            <= '0;
      line_base    <= '0;
      frames_left  <= '0;
      lvv_d        <= 1'b0;
      fvv_d        <= 1'b0;
      cam_enable   <= 1'b0;
      cam_request  <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      run_done     <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      err          <= '0;
    end else begin
      lvv_d       <= LVV;
      fvv_d       <= FVV;
      wr_en       <= 1'b0;
      cam_request <= 1'b0;
      frame_done  <= 1'b0;
      run_done    <= 1'b0;
      if (abort && state != IDLE && state != DONE) begin
        state      <= DONE;
        err[3]     <= 1'b1;
        cam_enable <= 1'b0;
        run_done   <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            state       <= ARM;
            frames_left <= num_frames == 8'd0 ? 8'd1 : num_frames;
            err         <= '0;
            cam_enable  <= 1'b1;
            cam_request <= 1'b1;
            busy        <= 1'b1;
          end
          ARM: begin
            state <= SYNC;
            tmo   <= '0;
          end
          SYNC, WAIT_FRAME: begin
            if (tmo_hit) begin
              state      <= DONE;
              err[2]     <= 1'b1;
              cam_enable <= 1'b0;
              run_done   <= 1'b1;
            end else if (state == SYNC && !FVV) begin
              state <= WAIT_FRAME;
              tmo   <= '0;
            end else if (state == WAIT_FRAME && FVV) begin
              state     <= CAPTURE;
              x         <= '0;
              y         <= '0;
              line_base <= '0;
            end else
              tmo <= tmo + TW'(1);
          end
          CAPTURE: begin
            if (q) begin
              if (fits) begin
                wr_en   <= 1'b1;
                wr_addr <= line_base + ADDR_W'(x);
                wr_data <= {blue, green, red};
                x       <= x + 16'd1;
              end else
                err[0] <= 1'b1;
            end
            if (close) begin
              if (y == 16'd0)
                frame_width <= x;
              else if (x != frame_width)
                err[1] <= 1'b1;
              y <= y + 16'd1;
              x <= '0;
              if (y < 16'(MAX_HEIGHT - 1))
                line_base <= line_base + ADDR_W'(MAX_WIDTH);
            end
            if (fall_f) begin
              frame_height <= y + {15'd0, close};
              frame_done   <= 1'b1;
              frames_left  <= frames_left - 8'd1;
              if (frames_left == 8'd1) begin
                state      <= DONE;
                cam_enable <= 1'b0;
                run_done   <= 1'b1;
              end else begin
                state <= WAIT_FRAME;
                tmo   <= '0;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cameralink_capture_ctl.sv
// tb_cameralink_capture_ctl: randomized self-checking bench against a line-length based frame model
module tb_cameralink_capture_ctl;
  localparam int MW = 16;
  localparam int MH = 6;
  localparam int AW = 7;
  localparam int TO = 200;
  logic CLOCK = 1'b0, RESET = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] num_frames = '0;
  logic VCE = 1'b0, LVV = 1'b0, FVV = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic cam_enable, cam_request, wr_en, busy, frame_done, run_done;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [15:0] frame_width, frame_height;
  logic [3:0] err;
  int total = 0, bad = 0, n_fd = 0, n_rd = 0;
  int exp_addr[$];
  logic [23:0] exp_data[$];
  int lens[$], plan[$];
  int mw, mh, me;
  cameralink_capture_ctl #(.MAX_WIDTH(MW), .MAX_HEIGHT(MH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .num_frames(num_frames), .abort(abort),
    .VCE(VCE), .LVV(LVV), .FVV(FVV), .red(red), .green(green), .blue(blue),
    .cam_enable(cam_enable), .cam_request(cam_request), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done), .run_done(run_done),
    .frame_width(frame_width), .frame_height(frame_height), .err(err));
  always #5 CLOCK = ~CLOCK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask
  always @(negedge CLOCK) if (!RESET) begin
    if (frame_done) n_fd++;
    if (run_done) n_rd++;
    if (wr_en) begin
      check("wr_expected", 32'(exp_addr.size() != 0), 1);
      if (exp_addr.size() != 0) begin
        check("wr_addr", 32'(wr_addr), exp_addr.pop_front());
        check("wr_data", 32'(wr_data), 32'(exp_data.pop_front()));
      end
    end
  end
  function automatic void model();
    mw = 0; mh = 0; me = 0;
    foreach (lens[i]) if (lens[i] > 0) begin
      if (lens[i] > MW || mh >= MH) me |= 1;
      if (mh < MH) begin
        if (mh == 0) mw = lens[i] > MW ? MW : lens[i];
        else if ((lens[i] > MW ? MW : lens[i]) != mw) me |= 2;
        mh++;
      end
    end
  endfunction
  task automatic drive_frame(input bit cap, input bit sim);
    int ln, p;
    ln = 0;
    FVV = 1; LVV = 0; VCE = 0;
    tick; tick;
    foreach (lens[i]) begin
      LVV = 1;
      if (lens[i] == 0) begin VCE = 0; tick; end
      p = 0;
      while (p < lens[i]) begin
        VCE = $urandom_range(0, 3) != 0;
        {blue, green, red} = 24'($urandom);
        if (VCE) begin
          if (cap && p < MW && ln < MH) begin
            exp_addr.push_back(ln * MW + p);
            exp_data.push_back({blue, green, red});
          end
          p++;
        end
        tick;
      end
      VCE = 0; LVV = 0;
      if (sim && i == lens.size() - 1) FVV = 0;
      tick;
      repeat ($urandom_range(0, 2)) tick;
      if (lens[i] > 0) ln++;
    end
    FVV = 0;
    tick; tick;
  endtask
  task automatic run(input int nf, input bit rnd, input bit mid);
    int nd, er, fd0, rd0;
    fd0 = n_fd; rd0 = n_rd; er = 0;
    nd = nf == 0 ? 1 : nf;
    num_frames = 8'(nf);
    if (mid) begin FVV = 1; LVV = 1; VCE = 1; tick; tick; end
    start = 1; tick; start = 0;
    if (mid) begin
      lens = '{5, 5};
      drive_frame(0, 0);
    end
    repeat (3) tick;
    for (int f = 0; f < nd; f++) begin
      if (rnd) begin
        lens.delete();
        lens.push_back($urandom_range(1, MW + 2));
        repeat ($urandom_range(0, MH - 1))
          lens.push_back($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, MW + 2));
      end else lens = plan;
      model();
      er |= me;
      if (f > 0) begin start = 1; tick; start = 0; end
      drive_frame(1, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      check("frame_width", 32'(frame_width), mw);
      check("frame_height", 32'(frame_height), mh);
    end
    tick; tick;
    check("run_err", 32'(err), er);
    check("frame_done_cnt", n_fd - fd0, nd);
    check("run_done_cnt", n_rd - rd0, 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_cam_enable", 32'(cam_enable), 0);
    check("writes_left", exp_addr.size(), 0);
  endtask
  initial begin
    int cyc, rd0;
    repeat (3) tick;
    RESET = 0;
    tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_cam_enable", 32'(cam_enable), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_err", 32'(err), 0);
    check("rst_width", 32'(frame_width), 0);
    check("rst_height", 32'(frame_height), 0);
    abort = 1; tick; abort = 0; tick;
    check("abort_idle_busy", 32'(busy), 0);
    check("abort_idle_rd", n_rd, 0);
    num_frames = 1; start = 1; tick; start = 0;
    check("arm_request", 32'(cam_request), 1);
    check("arm_enable", 32'(cam_enable), 1);
    tick;
    check("request_pulse", 32'(cam_request), 0);
    RESET = 1; tick; RESET = 0; tick;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rd", n_rd, 0);
    plan = '{4, 4, 4};      run(1, 0, 0);
    plan = '{4, 4, 4};      run(1, 0, 1);
    plan = '{MW + 2, MW};   run(1, 0, 0);
    plan = '{4, 4, 3};      run(1, 0, 0);
    plan = '{4, 0, 4, 4};   run(2, 0, 0);
    plan = '{3, 3};         run(0, 0, 0);
    for (int k = 0; k < 8; k++) run($urandom_range(1, 3), 1, 0);
    rd0 = n_rd;
    num_frames = 1; start = 1; tick; start = 0;
    cyc = 0;
    while (cyc < TO + 20 && !run_done) begin tick; cyc++; end
    check("tmo_done", 32'(run_done), 1);
    check("tmo_len_ok", 32'(cyc >= TO && cyc <= TO + 4), 1);
    check("tmo_err", 32'(err), 4'b0100);
    check("tmo_cam_enable", 32'(cam_enable), 0);
    tick; tick;
    check("tmo_rd_cnt", n_rd - rd0, 1);
    rd0 = n_rd;
    start = 1; tick; start = 0; repeat (3) tick;
    FVV = 1; tick; tick; LVV = 1; VCE = 1;
    for (int p = 0; p < 3; p++) begin
      {blue, green, red} = 24'($urandom);
      exp_addr.push_back(p);
      exp_data.push_back({blue, green, red});
      tick;
    end
    abort = 1; {blue, green, red} = 24'($urandom); tick; abort = 0;
    check("abort_done", 32'(run_done), 1);
    check("abort_cam_enable", 32'(cam_enable), 0);
    repeat (4) tick;
    VCE = 0; LVV = 0; FVV = 0; tick; tick;
    check("abort_err", 32'(err), 4'b1000);
    check("abort_rd_cnt", n_rd - rd0, 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_writes_left", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
